// File: rtl/hc595_rx_monitor_pkg.sv
// ============================================================================
// Module   : hc595_rx_monitor_pkg
// Brief    : Shared seven-segment definitions and frame-state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hc595_rx_monitor_pkg;

  localparam int SEG_W  = 7;
  localparam int SEL_W  = 8;
  localparam int DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFTING = 2'd1,
    ST_FULL     = 2'd2,
    ST_OVER     = 2'd3
  } frame_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } seg_dec_t;

  // Active-low segment codes {g,f,e,d,c,b,a} for hex digits 0-F.
  function automatic logic [SEG_W-1:0] seg_code(input logic [3:0] n);
    logic [SEG_W-1:0] c;
    case (n)
      4'h0: c = 7'h40;
      4'h1: c = 7'h79;
      4'h2: c = 7'h24;
      4'h3: c = 7'h30;
      4'h4: c = 7'h19;
      4'h5: c = 7'h12;
      4'h6: c = 7'h02;
      4'h7: c = 7'h78;
      4'h8: c = 7'h00;
      4'h9: c = 7'h10;
      4'hA: c = 7'h08;
      4'hB: c = 7'h03;
      4'hC: c = 7'h46;
      4'hD: c = 7'h21;
      4'hE: c = 7'h06;
      default: c = 7'h0E;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hc595_rx_monitor_hex_seg_decode.sv
// ============================================================================
// Module   : hex_seg_decode
// Brief    : Reverse lookup of an active-low 7-segment code to a hex nibble.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_seg_decode
  import hc595_rx_monitor_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output seg_dec_t         dec_o
);

  always_comb begin
    dec_o = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == seg_code(4'(i))) begin
        dec_o.valid  = 1'b1;
        dec_o.nibble = 4'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/hc595_rx_monitor.sv
// ============================================================================
// Module   : hc595_rx_monitor
// Brief    : 74HC595 link receiver: oversampled DS/SH_CP/ST_CP, word rebuild,
//            optional digit decode enabled by macro HC595_RX_DIGIT_DECODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hc595_rx_monitor
  import hc595_rx_monitor_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ds,
  input  logic             sh_cp,
  input  logic             st_cp,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic [31:0]      disp_data,
  output logic [7:0]       digit_seen,
  output logic             seg_err
);

  localparam int               CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(WIDTH + 1);

  function automatic frame_state_e state_of(input logic [CNT_W-1:0] cnt);
    if (cnt == '0)            return ST_IDLE;
    else if (cnt < CNT_FULL)  return ST_SHIFTING;
    else if (cnt == CNT_FULL) return ST_FULL;
    else                      return ST_OVER;
  endfunction

  logic [2:0] sh_sync_q, st_sync_q;
  logic [1:0] ds_sync_q;
  logic       sh_rise_q, st_rise_q, ds_bit_q;

  // Edge pulses are registered together with the data bit so a shift always
  // sees the ds value that was stable when sh_cp rose.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_sync_q <= '0;
      st_sync_q <= '0;
      ds_sync_q <= '0;
      sh_rise_q <= 1'b0;
      st_rise_q <= 1'b0;
      ds_bit_q  <= 1'b0;
    end else begin
      sh_sync_q <= {sh_sync_q[1:0], sh_cp};
      st_sync_q <= {st_sync_q[1:0], st_cp};
      ds_sync_q <= {ds_sync_q[0], ds};
      sh_rise_q <= sh_sync_q[1] & ~sh_sync_q[2];
      st_rise_q <= st_sync_q[1] & ~st_sync_q[2];
      ds_bit_q  <= ds_sync_q[1];
    end
  end

  frame_state_e     state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_out_q, data_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_valid_q, data_valid_d, frame_err_q, frame_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // A latch coinciding with a shift captures the pre-shift word; the new bit
  // then starts the next frame.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (st_rise_q) begin
      data_out_d   = shift_q;
      data_valid_d = 1'b1;
      frame_err_d  = (state_q != ST_FULL) | ~shift_q[WIDTH-1];
      cnt_d        = '0;
    end
    if (sh_rise_q) begin
      shift_d = {shift_q[WIDTH-2:0], ds_bit_q};
      if (st_rise_q)              cnt_d = CNT_W'(1);
      else if (cnt_q != CNT_OVER) cnt_d = cnt_q + CNT_W'(1);
    end
    state_d = state_of(cnt_d);
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;

`ifdef HC595_RX_DIGIT_DECODE_EN
  logic [14:0]      dec_word_q;
  logic             dec_req_q;
  logic [31:0]      disp_q, disp_d;
  logic [DIGITS-1:0] seen_q, seen_d;
  logic             seg_err_q, seg_err_d;
  logic [SEL_W-1:0] sel_norm;
  logic             sel_onehot;
  seg_dec_t         seg_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_word_q <= '0;
      dec_req_q  <= 1'b0;
      disp_q     <= '0;
      seen_q     <= '0;
      seg_err_q  <= 1'b0;
    end else begin
      if (st_rise_q) dec_word_q <= shift_q[14:0];
      dec_req_q <= data_valid_d & ~frame_err_d;
      disp_q    <= disp_d;
      seen_q    <= seen_d;
      seg_err_q <= seg_err_d;
    end
  end

  hex_seg_decode u_seg_decode (
    .seg_i (dec_word_q[14:8]),
    .dec_o (seg_dec)
  );

  assign sel_norm   = SEL_ACTIVE_LOW ? ~dec_word_q[7:0] : dec_word_q[7:0];
  assign sel_onehot = (sel_norm != '0) && ((sel_norm & (sel_norm - SEL_W'(1))) == '0);

  always_comb begin
    disp_d    = disp_q;
    seen_d    = seen_q;
    seg_err_d = 1'b0;
    if (dec_req_q) begin
      if (sel_onehot && seg_dec.valid) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (sel_norm[k]) begin
            disp_d[4*k +: 4] = seg_dec.nibble;
            seen_d[k]        = 1'b1;
          end
        end
      end else begin
        seg_err_d = 1'b1;
      end
    end
  end

  assign disp_data  = disp_q;
  assign digit_seen = seen_q;
  assign seg_err    = seg_err_q;
`else
  assign disp_data  = '0;
  assign digit_seen = '0;
  assign seg_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hc595_rx_monitor.sv
// ============================================================================
// Module   : tb_hc595_rx_monitor
// Brief    : Directed self-checking bench for hc595_rx_monitor; decode
//            expectations follow macro HC595_RX_DIGIT_DECODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hc595_rx_monitor;

`ifdef HC595_RX_DIGIT_DECODE_EN
  localparam int DEC = 1;
`else
  localparam int DEC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ds = 1'b0, sh_cp = 1'b0, st_cp = 1'b0;
  logic [15:0] data_out;
  logic        data_valid, frame_err, seg_err;
  logic [31:0] disp_data;
  logic [7:0]  digit_seen;

  int n_cmp = 0;
  int n_err = 0;
  int seg_cnt = 0;

  always #5 clk = ~clk;

  hc595_rx_monitor #(.WIDTH(16), .SEL_ACTIVE_LOW(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .ds         (ds),
    .sh_cp      (sh_cp),
    .st_cp      (st_cp),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .disp_data  (disp_data),
    .digit_seen (digit_seen),
    .seg_err    (seg_err)
  );

  always @(negedge clk) if (seg_err === 1'b1) seg_cnt++;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ds = v[i];
      repeat (3) @(negedge clk);
      sh_cp = 1'b1;
      repeat (3) @(negedge clk);
      sh_cp = 1'b0;
    end
  endtask

  // Raises st_cp, finds the data_valid pulse, then checks latency, width,
  // latched word, frame error and the number of seg_err cycles produced.
  task automatic do_latch(input string tag, input logic [15:0] exp_data,
                          input logic exp_ferr, input int exp_seg);
    int          base, lat;
    logic [15:0] d;
    logic        fe, dv2;
    base = seg_cnt;
    lat  = 0;
    d    = 'x;
    fe   = 1'bx;
    st_cp = 1'b1;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        lat = i;
        d   = data_out;
        fe  = frame_err;
      end
    end
    @(negedge clk);
    dv2 = data_valid;
    st_cp = 1'b0;
    repeat (6) @(negedge clk);
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_dv_width"}, dv2, 0);
    chk({tag, "_data"}, d, exp_data);
    chk({tag, "_ferr"}, fe, exp_ferr);
    chk({tag, "_seg_err"}, seg_cnt - base, exp_seg);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_disp", disp_data, 0);
    chk("rst_seen", digit_seen, 0);
    chk("rst_seg_err", seg_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    shift_bits(32'hC0FE, 16);
    do_latch("c0fe", 16'hC0FE, 1'b0, DEC);
    chk("c0fe_seen", digit_seen, 0);

    shift_bits(32'h1_8001, 17);
    do_latch("over17", 16'h8001, 1'b1, 0);
    shift_bits(32'h0001, 15);
    do_latch("short15", 16'h8001, 1'b1, 0);
    do_latch("relatch", 16'h8001, 1'b1, 0);

    shift_bits(32'hC001, 16);
    do_latch("dig0", 16'hC001, 1'b0, 0);
    chk("dig0_seen", digit_seen, DEC ? 32'h01 : 32'h0);

    shift_bits(32'hA101, 16); do_latch("scan0", 16'hA101, 1'b0, 0);
    shift_bits(32'hC602, 16); do_latch("scan1", 16'hC602, 1'b0, 0);
    shift_bits(32'h8304, 16); do_latch("scan2", 16'h8304, 1'b0, 0);
    shift_bits(32'h8808, 16); do_latch("scan3", 16'h8808, 1'b0, 0);
    shift_bits(32'h9910, 16); do_latch("scan4", 16'h9910, 1'b0, 0);
    shift_bits(32'hB020, 16); do_latch("scan5", 16'hB020, 1'b0, 0);
    shift_bits(32'hA440, 16); do_latch("scan6", 16'hA440, 1'b0, 0);
    shift_bits(32'hF980, 16); do_latch("scan7", 16'hF980, 1'b0, 0);
    chk("scan_disp", disp_data, DEC ? 32'h1234_ABCD : 32'h0);
    chk("scan_seen", digit_seen, DEC ? 32'hFF : 32'h0);

    shift_bits(32'hC003, 16);
    do_latch("sel_multi", 16'hC003, 1'b0, DEC);
    chk("sel_multi_disp", disp_data, DEC ? 32'h1234_ABCD : 32'h0);
    shift_bits(32'hFF01, 16);
    do_latch("seg_bad", 16'hFF01, 1'b0, DEC);
    chk("seg_bad_disp", disp_data, DEC ? 32'h1234_ABCD : 32'h0);
    shift_bits(32'h4001, 16);
    do_latch("pad0", 16'h4001, 1'b1, 0);
    chk("pad0_disp", disp_data, DEC ? 32'h1234_ABCD : 32'h0);

    // Last bit of the next frame rises together with the latch.
    shift_bits(32'hB010, 16);
    ds = 1'b1;
    repeat (3) @(negedge clk);
    sh_cp = 1'b1;
    do_latch("simul", 16'hB010, 1'b0, 0);
    sh_cp = 1'b0;
    chk("simul_disp", disp_data, DEC ? 32'h1233_ABCD : 32'h0);
    shift_bits(32'h7FFF, 15);
    do_latch("after_simul", 16'hFFFF, 1'b0, DEC);

    shift_bits(32'h00A5, 8);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_seen", digit_seen, 0);
    chk("midrst_disp", disp_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    shift_bits(32'hFFFF, 16);
    do_latch("post_rst", 16'hFFFF, 1'b0, DEC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
